// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// seq_divider: unsigned n-bit restoring divider, one quotient bit per cycle.
// Ports: clk, rst (sync, active high), start/x/y request; busy, done pulse, q, r, dbz results.
// Latency: done high n+1 cycles after acceptance (1 cycle for y==0); starts while busy are dropped.
module seq_divider #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] q,
  output logic [n-1:0] r,
  output logic         dbz
);

  localparam int cw = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state;
  logic [n:0]    rem;    // partial remainder, one bit wider than y
  logic [n-1:0]  dvd;    // dividend shifting out at the top, quotient filling in at the bottom
  logic [n-1:0]  ys;     // divisor captured at acceptance
  logic [cw-1:0] cnt;
  logic          zdiv;   // captured divisor was zero

  logic [n+1:0]  sh;
  logic [n+1:0]  diff;

  // sh never exceeds 2*y-1 < 2^(n+1), so diff[n+1] is a clean borrow bit.
  always_comb begin
    sh   = {rem, dvd[n-1]};
    diff = sh - {2'b00, ys};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      dvd   <= '0;
      ys    <= '0;
      cnt   <= '0;
      zdiv  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ys    <= y;
            dvd   <= x;
            rem   <= '0;
            cnt   <= cw'(n);
            zdiv  <= (y == '0);
            busy  <= 1'b1;
            state <= (y == '0) ? DONE : DIV;
          end
        end
        DIV: begin
          if (diff[n+1]) begin
            rem <= sh[n:0];
            dvd <= {dvd[n-2:0], 1'b0};
          end else begin
            rem <= diff[n:0];
            dvd <= {dvd[n-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
          if (cnt == cw'(1)) state <= DONE;
        end
        DONE: begin
          // On divide-by-zero dvd still holds the untouched dividend.
          done  <= 1'b1;
          busy  <= 1'b0;
          q     <= zdiv ? '1 : dvd;
          r     <= zdiv ? dvd : rem[n-1:0];
          dbz   <= zdiv;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x, y;
  logic       busy, done, dbz;
  logic [7:0] q, r;

  int tests = 0;
  int fails = 0;

  seq_divider #(.n(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vx;
    logic [7:0] vy;
    logic [7:0] eq;
    logic [7:0] er;
    logic       edbz;
    int         elat;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge following done.
  task automatic verify_op(input string tag, input logic [7:0] ax, input logic [7:0] ay,
                           input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                           input int elat);
    int lat;
    int bcnt;
    start = 1'b1; x = ax; y = ay;
    @(posedge clk); #1;
    start = 1'b0; x = 8'($urandom); y = 8'($urandom);
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    if (!done) begin
      check($sformatf("%s timeout x=%0d y=%0d", tag, ax, ay), 32'd0, 32'd1);
      return;
    end
    check($sformatf("%s q x=%0d y=%0d", tag, ax, ay), 32'(q), 32'(eq));
    check($sformatf("%s r x=%0d y=%0d", tag, ax, ay), 32'(r), 32'(er));
    check($sformatf("%s dbz x=%0d y=%0d", tag, ax, ay), 32'(dbz), 32'(edbz));
    check($sformatf("%s latency x=%0d y=%0d", tag, ax, ay), 32'(lat), 32'(elat));
    check($sformatf("%s busy_cycles x=%0d y=%0d", tag, ax, ay), 32'(bcnt), 32'(elat));
    @(posedge clk); #1;
    check($sformatf("%s done_single x=%0d y=%0d", tag, ax, ay), 32'(done), 32'd0);
    check($sformatf("%s q_hold x=%0d y=%0d", tag, ax, ay), 32'(q), 32'(eq));
  endtask

  initial begin
    int pulses;
    int dl;
    logic [7:0] cq, cr;
    logic [7:0] rx, ry, mq, mr;
    logic       mdbz;
    int         mlat;

    vt[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
    vt[1] = '{8'd3,   8'd200, 8'd0,   8'd3,   1'b0, 9};
    vt[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
    vt[3] = '{8'd5,   8'd0,   8'd255, 8'd5,   1'b1, 1};
    vt[4] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 9};
    vt[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
    vt[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
    vt[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9};
    vt[8] = '{8'd255, 8'd0,   8'd255, 8'd255, 1'b1, 1};
    vt[9] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 9};

    // Reset with start held high: start must be ignored.
    rst = 1'b1; start = 1'b1; x = 8'd20; y = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset q", 32'(q), 32'd0);
    check("reset r", 32'(r), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("post_reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++)
      verify_op($sformatf("vec%0d", i), vt[i].vx, vt[i].vy, vt[i].eq, vt[i].er,
                vt[i].edbz, vt[i].elat);

    // Start during DIV is dropped, never queued.
    start = 1'b1; x = 8'd200; y = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; dl = -1; cq = '0; cr = '0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin start = 1'b1; x = 8'd10; y = 8'd2; end
      else start = 1'b0;
      if (done) begin pulses++; dl = c; cq = q; cr = r; end
    end
    check("ignore pulses", 32'(pulses), 32'd1);
    check("ignore latency", 32'(dl), 32'd9);
    check("ignore q", 32'(cq), 32'd22);
    check("ignore r", 32'(cr), 32'd2);
    check("ignore busy_after", 32'(busy), 32'd0);

    // Reset mid-division: no done pulse, results cleared.
    start = 1'b1; x = 8'd100; y = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst = 1'b1; start = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort pulses", 32'(pulses), 32'd0);
    check("abort q", 32'(q), 32'd0);
    check("abort r", 32'(r), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    verify_op("after_abort", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);

    // Random operands against plain integer division.
    for (int i = 0; i < 1000; i++) begin
      int sel;
      rx  = 8'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0)      ry = 8'd0;
      else if (sel == 1) ry = 8'd255;
      else               ry = 8'($urandom);
      if (ry == 8'd0) begin
        mq = 8'd255; mr = rx; mdbz = 1'b1; mlat = 1;
      end else begin
        mq = rx / ry; mr = rx % ry; mdbz = 1'b0; mlat = 9;
      end
      verify_op("rand", rx, ry, mq, mr, mdbz, mlat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter n, default 8, operand/result width in bits (n >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 x  input  n  unsigned dividend; captured on accepted start.
REQ-006 y  input  n  unsigned divisor; captured on accepted start.
REQ-007 busy  output  1  high in DIV and DONE states.
REQ-008 done  output  1  single-cycle pulse; results are valid from this cycle onward.
REQ-009 q  output  n  quotient.
REQ-010 r  output  n  remainder.
REQ-011 dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 The block SHALL use three states: IDLE, DIV, DONE.
REQ-013 In IDLE with start=1, the block SHALL capture x and y, clear the partial remainder, load a step counter with n, and go to DIV; if y==0 it SHALL instead go directly to DONE.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE with all outputs held.
REQ-015 In DIV, each cycle SHALL perform one restoring step:
- shift {rem, dvd} left by 1;
- trial = rem - y (n+1-bit);
- if trial >= 0, rem = trial and the quotient LSB = 1;
- otherwise rem is unchanged and the quotient LSB = 0.
REQ-016 DIV SHALL last exactly n cycles, decrementing the counter each cycle, then go to DONE.
REQ-017 The partial remainder SHALL be n+1 bits wide internally so that no step overflows for any y in 1..2^n-1.
REQ-018 In DONE, the block SHALL assert done=1 for exactly one cycle, update q, r and dbz, then return to IDLE.
REQ-019 Latency: with start accepted on edge k and y!=0, done SHALL be high in the cycle after edge k+n+1.
- With y==0, done SHALL be high in the cycle after edge k+1.
REQ-020 q, r and dbz SHALL change only when done is asserted and SHALL hold until the next completion or reset.
REQ-021 If y==0: q SHALL be all ones, r SHALL equal x, and dbz SHALL be 1.
- Otherwise dbz SHALL be 0.
REQ-022 A start asserted in DIV or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-023 Changes on x or y after acceptance SHALL NOT affect the result in progress.
REQ-024 For y!=0 the results SHALL satisfy q*y + r == x and r < y.
REQ-025 busy SHALL be 0 in IDLE, so start may be asserted in the same cycle busy is low.
- Back-to-back operations SHALL be possible with one IDLE cycle between done and the next acceptance.

Reset
REQ-026 With rst=1 on a rising edge, the block SHALL go to IDLE.
- q=0, r=0, dbz=0, done=0, busy=0, counter=0.
REQ-027 Reset SHALL take priority over start and over any in-progress operation.
- A division interrupted by reset SHALL produce no done pulse.
- Its partial results SHALL never appear on q or r.
REQ-028 While rst is high, start SHALL be ignored.

Verification
REQ-029 n=8, x=100, y=7, start pulse: done 9 cycles after acceptance with q=14, r=2, dbz=0, busy high for exactly 9 cycles.
REQ-030 x=3, y=200: q=0, r=3, dbz=0; then x=255, y=1: q=255, r=0.
REQ-031 x=5, y=0: done 1 cycle after acceptance with q=255, r=5, dbz=1; a following x=9, y=3 run gives q=3, r=0, dbz=0.
REQ-032 x=200, y=9 accepted, then start with x=10, y=2 pulsed 3 cycles later: the second start is ignored; the result is q=22, r=2 and there is exactly one done pulse.
REQ-033 Start x=100, y=7, assert rst 4 cycles in: no done pulse, q=r=0, busy=0; after release, x=50, y=5 completes with q=10, r=0.
REQ-034 Run 1000 random (x, y) pairs including y=0 and y=255: each completion matches REQ-021/REQ-024 and each latency matches REQ-019.
